// File: rtl/line_fill_axi_pkg.sv
// Shared encodings for the line-fill AXI read back end: AXI burst/response
// codes, the default arcache value and the FSM state encoding.
package line_fill_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // AXI only allows WRAP bursts of 2, 4, 8 or 16 beats
  function automatic bit wrap_len_ok(input int beats);
    return (beats == 2) || (beats == 4) || (beats == 8) || (beats == 16);
  endfunction

endpackage

// File: rtl/line_fill_axi_beat_cnt.sv
// line_fill_beat_cnt: modulo 2**LINE2MEM_W beat counter for one line burst.
// The beat index starts at a loaded start beat and wraps; the count itself
// always runs 0..BEATS-1 so completion does not depend on the start beat.
module line_fill_beat_cnt
  import line_fill_axi_pkg::*;
#(
  parameter  int LINE2MEM_W = 3,
  localparam int CNT_W      = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] start_i,
  input  logic             beat_i,
  input  logic             rlast_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             last_o,
  output logic             rlast_err_o
);

  localparam int BEATS = 1 << LINE2MEM_W;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] start_q;

  // Load the start beat per request; advance on each beat, wrap after the final one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      start_q <= '0;
    end else if (load_i) begin
      cnt_q   <= '0;
      start_q <= start_i;
    end else if (beat_i) begin
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Index arithmetic wraps naturally at 2**CNT_W, which equals BEATS when LINE2MEM_W > 0
  assign idx_o       = start_q + cnt_q;
  assign last_o      = (cnt_q == CNT_W'(BEATS - 1));
  assign rlast_err_o = rlast_i ^ last_o;

endmodule

// File: rtl/line_fill_axi.sv
// line_fill_axi: AXI4 read back end for cache line refill. One burst per
// line, bounded reissue on error responses, sticky error to the front end.
// Optional critical-word-first WRAP bursts under macro CACHE_AXI_CWF_EN.
module line_fill_axi
  import line_fill_axi_pkg::*;
#(
  parameter  int FE_ADDR_W  = 32,
  parameter  int FE_DATA_W  = 32,
  parameter  int WORD_OFF_W = 3,
  parameter  int BE_ADDR_W  = FE_ADDR_W,
  parameter  int BE_DATA_W  = FE_DATA_W,
  parameter  int RETRY_MAX  = 2,
  parameter  int AXI_ID_W   = 1,
  parameter  int AXI_ID     = 0,
  localparam int FE_BYTE_W  = $clog2(FE_DATA_W / 8),
  localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int IDX_W      = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        replace_valid,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] replace_addr,
  output logic                        replace,
  output logic                        read_valid,
  output logic [IDX_W-1:0]            read_addr,
  output logic [BE_DATA_W-1:0]        read_rdata,
  output logic                        read_error,
  output logic                        axi_arvalid,
  output logic [BE_ADDR_W-1:0]        axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic                        axi_arlock,
  output logic [3:0]                  axi_arcache,
  output logic [2:0]                  axi_arprot,
  output logic [3:0]                  axi_arqos,
  output logic [AXI_ID_W-1:0]         axi_arid,
  input  logic                        axi_arready,
  input  logic                        axi_rvalid,
  input  logic [BE_DATA_W-1:0]        axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rlast,
  output logic                        axi_rready
);

  localparam int BE_BYTE_W  = $clog2(BE_DATA_W / 8);
  localparam int BEATS      = 1 << LINE2MEM_W;
  localparam int LINE_OFF_W = WORD_OFF_W + FE_BYTE_W;
  localparam int RETRY_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
`ifdef CACHE_AXI_CWF_EN
  localparam bit CWF = wrap_len_ok(BEATS);
`else
  localparam bit CWF = 1'b0;
`endif

  state_t               state_q;
  logic                 replace_q, arvalid_q, rready_q, read_error_q;
  logic                 berr_q, holdoff_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [BE_ADDR_W-1:0] araddr_q;

  logic [FE_ADDR_W-1:0] req_byte_addr;
  logic [BE_ADDR_W-1:0] req_be_addr, line_base, beat_addr;
  logic [IDX_W-1:0]     start_beat, beat_idx;
  logic                 accept, beat, last_beat, rlast_err, beat_err, burst_err;

  assign req_byte_addr = FE_ADDR_W'(replace_addr) << FE_BYTE_W;
  assign req_be_addr   = BE_ADDR_W'(req_byte_addr);
  assign line_base     = req_be_addr & ~((BE_ADDR_W'(1) << LINE_OFF_W) - BE_ADDR_W'(1));
  assign beat_addr     = req_be_addr & ~((BE_ADDR_W'(1) << BE_BYTE_W) - BE_ADDR_W'(1));
  assign start_beat    = CWF ? IDX_W'(req_be_addr >> BE_BYTE_W) : '0;

  // holdoff_q keeps the request still held for the finished refill from restarting it
  assign accept    = (state_q == ST_IDLE) && replace_valid && !holdoff_q;
  assign beat      = axi_rvalid && rready_q;
  assign beat_err  = (axi_rresp != RESP_OKAY) || rlast_err;
  assign burst_err = berr_q || beat_err;

  line_fill_beat_cnt #(
    .LINE2MEM_W(LINE2MEM_W)
  ) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .start_i    (start_beat),
    .beat_i     (beat),
    .rlast_i    (axi_rlast),
    .idx_o      (beat_idx),
    .last_o     (last_beat),
    .rlast_err_o(rlast_err)
  );

  // Request address is latched once; reissues reuse it unchanged
  always_ff @(posedge clk) begin
    if (accept) araddr_q <= CWF ? beat_addr : line_base;
  end

  // Refill FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      replace_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      read_error_q <= 1'b0;
      berr_q       <= 1'b0;
      holdoff_q    <= 1'b0;
      retry_q      <= '0;
    end else begin
      holdoff_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_ADDR;
            replace_q    <= 1'b1;
            arvalid_q    <= 1'b1;
            read_error_q <= 1'b0;
            retry_q      <= '0;
            berr_q       <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (axi_arready) begin
            state_q   <= ST_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (beat) begin
            if (!last_beat) begin
              berr_q <= burst_err;
            end else begin
              berr_q   <= 1'b0;
              rready_q <= 1'b0;
              if (burst_err && (retry_q < RETRY_W'(RETRY_MAX))) begin
                state_q   <= ST_ADDR;
                arvalid_q <= 1'b1;
                retry_q   <= retry_q + 1'b1;
              end else begin
                state_q      <= ST_IDLE;
                replace_q    <= 1'b0;
                holdoff_q    <= 1'b1;
                read_error_q <= burst_err;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign replace     = replace_q;
  assign read_valid  = beat;
  assign read_addr   = beat_idx;
  assign read_rdata  = axi_rdata;
  assign read_error  = read_error_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_arsize  = 3'(BE_BYTE_W);
  assign axi_arburst = CWF ? BURST_WRAP : BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = ARCACHE_DEFAULT;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'b0000;
  assign axi_arid    = AXI_ID_W'(AXI_ID);
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_line_fill_axi.sv
// Bench for line_fill_axi: default 32/32 instance plus a 128-bit single-beat
// instance. Expectations follow CACHE_AXI_CWF_EN when it is defined.
module tb_line_fill_axi;

  localparam int BEATS = 8;
`ifdef CACHE_AXI_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default instance signals
  logic        replace_valid;
  logic [29:0] replace_addr;
  logic        replace, read_valid, read_error;
  logic [2:0]  read_addr;
  logic [31:0] read_rdata;
  logic        axi_arvalid, axi_arlock, axi_arready, axi_rvalid, axi_rlast, axi_rready;
  logic [31:0] axi_araddr, axi_rdata;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize, axi_arprot;
  logic [1:0]  axi_arburst, axi_rresp;
  logic [3:0]  axi_arcache, axi_arqos;
  logic [0:0]  axi_arid;

  // wide instance signals
  logic         w_replace_valid;
  logic [29:0]  w_replace_addr;
  logic         w_replace, w_read_valid, w_read_error;
  logic [0:0]   w_read_addr;
  logic [127:0] w_read_rdata, w_axi_rdata;
  logic         w_axi_arvalid, w_axi_arlock, w_axi_arready, w_axi_rvalid, w_axi_rlast, w_axi_rready;
  logic [31:0]  w_axi_araddr;
  logic [7:0]   w_axi_arlen;
  logic [2:0]   w_axi_arsize, w_axi_arprot;
  logic [1:0]   w_axi_arburst, w_axi_rresp;
  logic [3:0]   w_axi_arcache, w_axi_arqos;
  logic [0:0]   w_axi_arid;

  int n_run  = 0;
  int n_fail = 0;
  int ar_count;
  int pulses;

  line_fill_axi dut (
    .clk(clk), .reset(reset),
    .replace_valid(replace_valid), .replace_addr(replace_addr),
    .replace(replace), .read_valid(read_valid), .read_addr(read_addr),
    .read_rdata(read_rdata), .read_error(read_error),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
    .axi_arid(axi_arid), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready)
  );

  line_fill_axi #(.WORD_OFF_W(2), .BE_DATA_W(128)) dut_w (
    .clk(clk), .reset(reset),
    .replace_valid(w_replace_valid), .replace_addr(w_replace_addr),
    .replace(w_replace), .read_valid(w_read_valid), .read_addr(w_read_addr),
    .read_rdata(w_read_rdata), .read_error(w_read_error),
    .axi_arvalid(w_axi_arvalid), .axi_araddr(w_axi_araddr), .axi_arlen(w_axi_arlen),
    .axi_arsize(w_axi_arsize), .axi_arburst(w_axi_arburst), .axi_arlock(w_axi_arlock),
    .axi_arcache(w_axi_arcache), .axi_arprot(w_axi_arprot), .axi_arqos(w_axi_arqos),
    .axi_arid(w_axi_arid), .axi_arready(w_axi_arready),
    .axi_rvalid(w_axi_rvalid), .axi_rdata(w_axi_rdata), .axi_rresp(w_axi_rresp),
    .axi_rlast(w_axi_rlast), .axi_rready(w_axi_rready)
  );

  // Reference model: burst address and first beat from the missed word address
  function automatic logic [31:0] model_araddr(input logic [29:0] wa);
    logic [31:0] b;
    b = {wa, 2'b00};
    return CWF ? (b & 32'hFFFF_FFFC) : (b & 32'hFFFF_FFE0);
  endfunction

  function automatic int model_start(input logic [29:0] wa);
    return CWF ? int'(wa % BEATS) : 0;
  endfunction

  // Raise a request and confirm replace rises on the following cycle
  task automatic issue_req(input logic [29:0] wa);
    @(posedge clk); #1;
    replace_valid = 1'b1;
    replace_addr  = wa;
    @(negedge clk);
    n_run++;
    if (replace !== 1'b0) begin
      n_fail++; $display("FAIL replace_early got=%b exp=0", replace);
    end
    @(negedge clk);
    n_run++;
    if (replace !== 1'b1 || read_error !== 1'b0) begin
      n_fail++; $display("FAIL accept got replace=%b read_error=%b exp replace=1 read_error=0", replace, read_error);
    end
  endtask

  // Serve one burst as an AXI slave and score every forwarded beat.
  // err_beat: -1 none, 99 every beat, else that beat gets err_resp.
  task automatic do_burst(input logic [31:0] exp_addr, input int start, input int err_beat,
                          input logic [1:0] err_resp, input int early_last,
                          input bit final_b, input int abort_beat);
    int waited;
    logic [31:0] d;
    logic [1:0]  exp_burst;
    exp_burst = CWF ? 2'b10 : 2'b01;
    waited = 0;
    while (!axi_arvalid && waited < 40) begin
      @(negedge clk); waited++;
    end
    n_run++;
    if (axi_arvalid !== 1'b1) begin
      n_fail++; $display("FAIL ar_timeout got arvalid=%b exp=1", axi_arvalid);
      return;
    end
    n_run++;
    if (axi_araddr !== exp_addr || axi_arburst !== exp_burst || axi_arlen !== 8'd7 ||
        axi_arsize !== 3'd2 || replace !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_fields got addr=%h burst=%b len=%0d size=%0d replace=%b exp addr=%h burst=%b len=7 size=2 replace=1",
               axi_araddr, axi_arburst, axi_arlen, axi_arsize, replace, exp_addr, exp_burst);
    end
    n_run++;
    if ({axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arid} !== {1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL ar_const got lock=%b cache=%b prot=%b qos=%b id=%b exp 0/0011/000/0000/0",
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arid);
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      n_run++;
      if (axi_arvalid !== 1'b1 || axi_araddr !== exp_addr) begin
        n_fail++; $display("FAIL ar_stable got arvalid=%b addr=%h exp 1/%h", axi_arvalid, axi_araddr, exp_addr);
      end
    end
    @(posedge clk); #1;
    axi_arready = 1'b1;
    @(posedge clk); #1;
    axi_arready = 1'b0;
    ar_count++;
    n_run++;
    if (axi_arvalid !== 1'b0 || axi_rready !== 1'b1) begin
      n_fail++; $display("FAIL ar_done got arvalid=%b rready=%b exp 0/1", axi_arvalid, axi_rready);
    end
    for (int k = 0; k < BEATS; k++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
      d = $urandom;
      axi_rvalid = 1'b1;
      axi_rdata  = d;
      if (k == abort_beat) begin
        #1 reset = 1'b1;
        #1;
        n_run++;
        if (axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || replace !== 1'b0 || read_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL async_reset got arvalid=%b rready=%b replace=%b read_valid=%b exp all 0",
                   axi_arvalid, axi_rready, replace, read_valid);
        end
        axi_rvalid    = 1'b0;
        replace_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      axi_rresp = (err_beat == 99 || err_beat == k) ? err_resp : 2'b00;
      axi_rlast = (early_last >= 0) ? (k == early_last) : (k == BEATS - 1);
      @(negedge clk);
      n_run++;
      if (read_valid !== 1'b1 || read_addr !== 3'((start + k) % BEATS) || read_rdata !== d || replace !== 1'b1) begin
        n_fail++;
        $display("FAIL beat%0d got valid=%b idx=%0d data=%h replace=%b exp 1/%0d/%h/1",
                 k, read_valid, read_addr, read_rdata, replace, (start + k) % BEATS, d);
      end
      if (read_valid === 1'b1) pulses++;
      @(posedge clk); #1;
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      axi_rresp  = 2'b00;
    end
    n_run++;
    if (final_b) begin
      if (replace !== 1'b0 || axi_arvalid !== 1'b0 || axi_rready !== 1'b0) begin
        n_fail++; $display("FAIL end_idle got replace=%b arvalid=%b rready=%b exp 0/0/0", replace, axi_arvalid, axi_rready);
      end
      replace_valid = 1'b0;
    end else begin
      if (replace !== 1'b1 || axi_arvalid !== 1'b1) begin
        n_fail++; $display("FAIL reissue got replace=%b arvalid=%b exp 1/1", replace, axi_arvalid);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    n_run++;
    if ({replace, read_valid, read_error, axi_arvalid, axi_rready} !== 5'b0 || read_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got rep=%b rv=%b err=%b arv=%b rrdy=%b idx=%0d exp all 0",
               replace, read_valid, read_error, axi_arvalid, axi_rready, read_addr);
    end
    n_run++;
    if ({w_replace, w_read_valid, w_read_error, w_axi_arvalid, w_axi_rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_wide got %b exp 00000", {w_replace, w_read_valid, w_read_error, w_axi_arvalid, w_axi_rready});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    ar_count = 0; pulses = 0;
    issue_req(30'h105);
    do_burst(model_araddr(30'h105), model_start(30'h105), -1, 2'b10, -1, 1'b1, -1);
    n_run++;
    if (pulses !== 8 || ar_count !== 1 || read_error !== 1'b0) begin
      n_fail++; $display("FAIL basic got pulses=%0d ar=%0d err=%b exp 8/1/0", pulses, ar_count, read_error);
    end
  endtask

  task automatic test_retry_once;
    logic [29:0] wa;
    wa = 30'($urandom);
    ar_count = 0; pulses = 0;
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), 3, 2'b10, -1, 1'b0, -1);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
    n_run++;
    if (pulses !== 16 || ar_count !== 2 || read_error !== 1'b0) begin
      n_fail++; $display("FAIL retry_once got pulses=%0d ar=%0d err=%b exp 16/2/0", pulses, ar_count, read_error);
    end
  endtask

  task automatic test_retry_exhaust;
    logic [29:0] wa;
    wa = 30'($urandom);
    ar_count = 0; pulses = 0;
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), 99, 2'b10, -1, 1'b0, -1);
    do_burst(model_araddr(wa), model_start(wa), 99, 2'b11, -1, 1'b0, -1);
    do_burst(model_araddr(wa), model_start(wa), 99, 2'b10, -1, 1'b1, -1);
    n_run++;
    if (read_error !== 1'b1 || ar_count !== 3) begin
      n_fail++; $display("FAIL exhaust got err=%b ar=%0d exp 1/3", read_error, ar_count);
    end
    repeat (4) @(negedge clk);
    n_run++;
    if (axi_arvalid !== 1'b0 || read_error !== 1'b1) begin
      n_fail++; $display("FAIL exhaust_idle got arvalid=%b err=%b exp 0/1", axi_arvalid, read_error);
    end
    wa = 30'($urandom);
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
  endtask

  task automatic test_rlast_err;
    logic [29:0] wa;
    wa = 30'($urandom);
    ar_count = 0;
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, 2, 1'b0, -1);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
    n_run++;
    if (ar_count !== 2 || read_error !== 1'b0) begin
      n_fail++; $display("FAIL rlast_err got ar=%0d err=%b exp 2/0", ar_count, read_error);
    end
  endtask

  task automatic test_reset_mid;
    logic [29:0] wa;
    wa = 30'($urandom);
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, 4);
    wa = 30'($urandom);
    pulses = 0;
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
    n_run++;
    if (pulses !== 8 || read_error !== 1'b0) begin
      n_fail++; $display("FAIL after_reset got pulses=%0d err=%b exp 8/0", pulses, read_error);
    end
  endtask

  // Request held across completion: acceptance waits a full cycle after replace falls
  task automatic test_back_to_back;
    logic [29:0] wa;
    wa = 30'($urandom);
    issue_req(wa);
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
    wa = 30'($urandom);
    replace_valid = 1'b1;
    replace_addr  = wa;
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (replace !== 1'b0) begin
      n_fail++; $display("FAIL holdoff got replace=%b exp 0", replace);
    end
    @(negedge clk);
    n_run++;
    if (replace !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept got replace=%b exp 1", replace);
    end
    do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
  endtask

  task automatic test_random;
    logic [29:0] wa;
    int eb;
    for (int i = 0; i < 6; i++) begin
      wa = 30'($urandom);
      eb = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7));
      ar_count = 0; pulses = 0;
      issue_req(wa);
      if (eb >= 0) do_burst(model_araddr(wa), model_start(wa), eb, 2'($urandom_range(2, 3)), -1, 1'b0, -1);
      do_burst(model_araddr(wa), model_start(wa), -1, 2'b10, -1, 1'b1, -1);
      n_run++;
      if (pulses !== ((eb >= 0) ? 16 : 8) || ar_count !== ((eb >= 0) ? 2 : 1) || read_error !== 1'b0) begin
        n_fail++; $display("FAIL random%0d got pulses=%0d ar=%0d err=%b exp %0d/%0d/0",
                           i, pulses, ar_count, read_error, (eb >= 0) ? 16 : 8, (eb >= 0) ? 2 : 1);
      end
    end
  endtask

  // 128-bit back end with 4-word lines: single-beat INCR from the line base
  task automatic test_wide;
    logic [127:0] d;
    int waited;
    @(posedge clk); #1;
    w_replace_valid = 1'b1;
    w_replace_addr  = 30'h105;
    waited = 0;
    while (!w_axi_arvalid && waited < 20) begin
      @(negedge clk); waited++;
    end
    n_run++;
    if (w_axi_arvalid !== 1'b1 || w_axi_araddr !== 32'h410 || w_axi_arlen !== 8'd0 ||
        w_axi_arsize !== 3'd4 || w_axi_arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL wide_ar got arv=%b addr=%h len=%0d size=%0d burst=%b exp 1/00000410/0/4/01",
               w_axi_arvalid, w_axi_araddr, w_axi_arlen, w_axi_arsize, w_axi_arburst);
    end
    @(posedge clk); #1;
    w_axi_arready = 1'b1;
    @(posedge clk); #1;
    w_axi_arready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    w_axi_rvalid = 1'b1;
    w_axi_rdata  = d;
    w_axi_rlast  = 1'b1;
    @(negedge clk);
    n_run++;
    if (w_read_valid !== 1'b1 || w_read_addr !== 1'b0 || w_read_rdata !== d) begin
      n_fail++; $display("FAIL wide_beat got v=%b idx=%0d data=%h exp 1/0/%h", w_read_valid, w_read_addr, w_read_rdata, d);
    end
    @(posedge clk); #1;
    w_axi_rvalid    = 1'b0;
    w_axi_rlast     = 1'b0;
    w_replace_valid = 1'b0;
    n_run++;
    if (w_replace !== 1'b0 || w_read_error !== 1'b0) begin
      n_fail++; $display("FAIL wide_end got replace=%b err=%b exp 0/0", w_replace, w_read_error);
    end
  endtask

  initial begin
    replace_valid = 1'b0; replace_addr = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0;
    w_replace_valid = 1'b0; w_replace_addr = '0;
    w_axi_arready = 1'b0; w_axi_rvalid = 1'b0; w_axi_rdata = '0; w_axi_rresp = 2'b00; w_axi_rlast = 1'b0;
    test_reset();
    test_basic();
    test_retry_once();
    test_retry_exhaust();
    test_rlast_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
